// File: rtl/c_register.sv
// Generic holding register: captures in on a clk rising edge while save is high, else holds.
// Latency 1 cycle from sample to out; no backpressure, a load is accepted on every enabled edge.
module c_register #(
    parameter int BITS        = 16,
    parameter     RESET_VALUE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            save,
    input  logic [BITS-1:0] in,
    output logic [BITS-1:0] out
);

    if (BITS < 1) begin : g_bits_check
        $error("c_register: BITS must be 1 or more, got %0d", BITS);
    end

    // Reset value is cut or zero-padded to the register width.
    localparam logic [BITS-1:0] RST_VAL = BITS'(RESET_VALUE);

    logic [BITS-1:0] out_q;
    logic [BITS-1:0] out_d;

    always_comb begin
        out_d = out_q;
        if (save) begin
            out_d = in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= RST_VAL;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_c_register.sv
// Directed bench for c_register: default 16-bit instance plus 1-bit and 32-bit
// instances with a 0xDEADBEEF reset value, all checked against hand-computed values.
module tb_c_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        save;
    logic [15:0] din;
    logic [15:0] dout;

    logic        save_p;
    logic        din1;
    logic        dout1;
    logic [31:0] din32;
    logic [31:0] dout32;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    c_register u_dut (
        .clk  (clk),
        .rst  (rst),
        .save (save),
        .in   (din),
        .out  (dout)
    );

    c_register #(.BITS(1), .RESET_VALUE(32'hDEAD_BEEF)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .save (save_p),
        .in   (din1),
        .out  (dout1)
    );

    c_register #(.BITS(32), .RESET_VALUE(32'hDEAD_BEEF)) u_dut32 (
        .clk  (clk),
        .rst  (rst),
        .save (save_p),
        .in   (din32),
        .out  (dout32)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        save   = 1'b1;
        din    = 16'h5555;
        save_p = 1'b1;
        din1   = 1'b0;
        din32  = 32'h0000_0000;

        // Reset with save asserted and arbitrary data present.
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst16", 32'(dout), 32'h0000_0000);
        chk("rst1", 32'(dout1), 32'h0000_0001);
        chk("rst32", dout32, 32'hDEAD_BEEF);

        save   = 1'b0;
        save_p = 1'b0;
        #2 rst = 1'b1;
        tick();
        chk("rel16", 32'(dout), 32'h0000_0000);
        chk("rel32", dout32, 32'hDEAD_BEEF);

        // Single load of -16, then hold.
        save = 1'b1;
        din  = 16'hFFF0;
        tick();
        chk("load", 32'(dout), 32'h0000_FFF0);
        save = 1'b0;
        tick();
        chk("load_h1", 32'(dout), 32'h0000_FFF0);
        tick();
        chk("load_h2", 32'(dout), 32'h0000_FFF0);

        // Changing in while save is low must not disturb the contents.
        din = 16'h0020;
        tick();
        chk("hold1", 32'(dout), 32'h0000_FFF0);
        tick();
        chk("hold2", 32'(dout), 32'h0000_FFF0);

        // Back-to-back loads.
        save = 1'b1;
        din  = 16'h1234;
        tick();
        chk("b2b1", 32'(dout), 32'h0000_1234);
        din = 16'hABCD;
        tick();
        chk("b2b2", 32'(dout), 32'h0000_ABCD);
        save = 1'b0;

        // Parameter sweep: load zeros, then all-ones.
        save_p = 1'b1;
        din1   = 1'b0;
        din32  = 32'h0000_0000;
        tick();
        chk("p1_zero", 32'(dout1), 32'h0000_0000);
        chk("p32_zero", dout32, 32'h0000_0000);
        din1  = 1'b1;
        din32 = 32'hFFFF_FFFF;
        tick();
        chk("p1_ones", 32'(dout1), 32'h0000_0001);
        chk("p32_ones", dout32, 32'hFFFF_FFFF);
        din1  = 1'b0;
        din32 = 32'h0000_0000;
        tick();
        save_p = 1'b0;
        chk("p1_zero2", 32'(dout1), 32'h0000_0000);
        chk("ab_kept", 32'(dout), 32'h0000_ABCD);

        // Async reset between edges takes effect with no clock.
        #3 rst = 1'b0;
        #1;
        chk("async16", 32'(dout), 32'h0000_0000);
        chk("async1", 32'(dout1), 32'h0000_0001);
        chk("async32", dout32, 32'hDEAD_BEEF);

        save   = 1'b1;
        din    = 16'h7777;
        save_p = 1'b1;
        din32  = 32'h1111_1111;
        tick();
        chk("rst_save16", 32'(dout), 32'h0000_0000);
        chk("rst_save32", dout32, 32'hDEAD_BEEF);

        // After release the reset value holds until the next load.
        save   = 1'b0;
        save_p = 1'b0;
        #2 rst = 1'b1;
        tick();
        chk("post16", 32'(dout), 32'h0000_0000);
        chk("post32", dout32, 32'hDEAD_BEEF);
        save = 1'b1;
        din  = 16'h0001;
        tick();
        chk("post_load", 32'(dout), 32'h0000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/c_register.md
# c_register

Parameterised, edge-triggered storage register with a synchronous load enable and asynchronous active-low reset. It is the generic holding register for the datapath: it captures `in` on a clock edge only while `save` is asserted and otherwise holds its contents. It is instantiated wherever a value must persist across cycles, such as pipeline latches and architectural or temporary registers.

## Interface
Parameters:
- `BITS`, default 16: data width in bits. Legal range is 1 or more.
- `RESET_VALUE`, default 0: value loaded into the register on reset, truncated or zero-extended to `BITS`.

Ports:
- `clk`, input, 1 bit: single clock. All state changes on its rising edge.
- `rst`, input, 1 bit: reset, asynchronous and active-low. Asserting it (0) forces the register to `RESET_VALUE` immediately. It is held there while `rst` stays low.
- `save`, input, 1 bit: load enable, sampled on the rising edge of `clk`.
- `in`, input, `BITS` bits: data to capture.
- `out`, output, `BITS` bits: current register contents, driven directly from the flops.

## Operation
- One state element: a `BITS`-wide register driving `out`.
- `rst` = 0: the register becomes `RESET_VALUE` at once, with no clock needed. `save` and `in` are ignored.
- `rst` = 1, rising edge of `clk`, `save` = 1: the register takes `in`.
- `rst` = 1, rising edge of `clk`, `save` = 0: the register holds its value. Changes on `in` have no effect.
- Data is treated as an opaque bit vector, with no sign or arithmetic interpretation. For example, -16 at 16 bits is stored as 0xFFF0 and read back as 0xFFF0.
- `out` has no combinational path from `in` or `save`. It changes only on a `clk` rising edge or on reset assertion.
- `save` = X or Z on an edge while out of reset is a usage error. The design does not have to define the result; simulation may propagate X.

## Timing
- Reset assertion: `out` = `RESET_VALUE` within the same delta or time step as the falling edge of `rst`, independent of `clk`.
- Reset removal: the rising edge of `rst` takes effect synchronously. The first possible load is on the first `clk` rising edge where `rst` = 1 is already stable.
- Load latency: 1 cycle. `in` sampled at edge N appears on `out` just after edge N and stays until the next load or reset.
- Back-to-back loads: `save` held high loads `in` on every edge, so `out` follows `in` delayed by one cycle.
- Simultaneous reset assertion and load edge: reset wins and `out` = `RESET_VALUE`.
- Reset asserted mid-hold: contents are lost. After release the register holds `RESET_VALUE` until the next load.
- Power-up before any reset: contents are undefined, and no value is guaranteed.

## Structure
- Single flat module. Do not use a shared package or any sub-module.
- Implement as one always block sensitive to `posedge clk` and `negedge rst`.
- Include an elaboration-time check that `BITS` is 1 or more.

## Test plan
- Reset: hold `rst` = 0 for one period with `save` and `in` arbitrary -> `out` = 0x0000. Release `rst` -> `out` stays 0x0000.
- Load: `save` = 1, `in` = 0xFFF0 (-16) for one edge, then `save` = 0 -> `out` = 0xFFF0 after that edge and stays 0xFFF0 over the following two cycles.
- Hold: `save` = 0, `in` = 0x0020 (32) for two edges -> `out` remains 0xFFF0.
- Back-to-back: `save` = 1, `in` = 0x1234 then 0xABCD on consecutive edges -> `out` = 0x1234 then 0xABCD, each one cycle after sampling.
- Async reset mid-cycle: with `out` = 0xABCD, pull `rst` low between clock edges -> `out` = 0x0000 immediately, without waiting for a clock edge. With `save` = 1 during reset -> `out` stays 0x0000.
- Parameter sweep: `BITS` = 1 and `BITS` = 32 with `RESET_VALUE` = 0xDEADBEEF -> reset gives the truncated or exact reset value, and a load of all-ones reads back as all-ones.
